// File: rtl/isqrt_seq.sv
// Sequential restoring integer square root: one root bit per clock, valid/ready on both sides.
// Optional `ISQRT_EXACT_FLAG_EN adds a registered perfect-square output "exact".
module isqrt_seq #(
    parameter int BITWIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*BITWIDTH-1:0]   x,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BITWIDTH-1:0]     root,
    output logic [BITWIDTH:0]       rem
`ifdef ISQRT_EXACT_FLAG_EN
    ,
    output logic                    exact
`endif
);

    localparam int CNT_W = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [2*BITWIDTH-1:0] sr;
    logic [BITWIDTH+1:0]   r;
    logic [BITWIDTH-1:0]   root_part;
    logic [CNT_W-1:0]      cnt;

    logic [BITWIDTH+1:0]   r_shift;
    logic [BITWIDTH+1:0]   trial;
    logic                  ge;
    logic [BITWIDTH+1:0]   r_next;
    logic [BITWIDTH-1:0]   root_next;
    logic [2*BITWIDTH-1:0] sr_next;
    logic                  last_iter;

    // One restoring digit step: bring down the next radicand pair and try (root<<2)|1.
    always_comb begin
        r_shift   = {r[BITWIDTH-1:0], sr[2*BITWIDTH-1 -: 2]};
        trial     = {root_part, 2'b01};
        // The top two remainder bits are always zero before a shift; folding them in keeps the compare exact.
        ge        = (r[BITWIDTH+1:BITWIDTH] != 2'b00) || (r_shift >= trial);
        r_next    = ge ? (r_shift - trial) : r_shift;
        root_next = {root_part[BITWIDTH-2:0], ge};
        sr_next   = {sr[2*BITWIDTH-3:0], 2'b00};
        last_iter = (cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid)  state_next = CALC;
            CALC: if (last_iter) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: results are captured on the final iteration and held until the next acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr        <= '0;
            r         <= '0;
            root_part <= '0;
            cnt       <= '0;
            root      <= '0;
            rem       <= '0;
`ifdef ISQRT_EXACT_FLAG_EN
            exact     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sr        <= x;
                        r         <= '0;
                        root_part <= '0;
                        cnt       <= CNT_W'(BITWIDTH - 1);
                    end
                end
                CALC: begin
                    sr        <= sr_next;
                    r         <= r_next;
                    root_part <= root_next;
                    if (last_iter) begin
                        root  <= root_next;
                        rem   <= r_next[BITWIDTH:0];
`ifdef ISQRT_EXACT_FLAG_EN
                        exact <= (r_next == '0);
`endif
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_isqrt_seq.sv
// Self-checking bench for isqrt_seq: directed vector table, handshake corner cases,
// and a randomized back-to-back stream against a floating-point-seeded sqrt model.
module tb_isqrt_seq;

    localparam int W = 32;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2*W-1:0]  x;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    root;
    logic [W:0]      rem;
`ifdef ISQRT_EXACT_FLAG_EN
    logic            exact;
`endif

    int nchecks = 0;
    int nerrors = 0;

    isqrt_seq #(.BITWIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .root      (root),
        .rem       (rem)
`ifdef ISQRT_EXACT_FLAG_EN
        ,
        .exact     (exact)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] x;
        logic [W-1:0]   root;
        logic [W:0]     rem;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: floating-point estimate refined with exact 128-bit integer arithmetic.
    function automatic logic [63:0] model_root(input logic [63:0] v);
        real            fr;
        longint         est;
        logic [127:0]   rr;
        logic [127:0]   vv;
        fr  = $sqrt(real'(v));
        est = longint'(fr);
        if (est < 0) est = 0;
        if (est > 64'sh0FFFFFFFF) est = 64'sh0FFFFFFFF;
        rr = {64'd0, est};
        vv = {64'd0, v};
        while (rr * rr > vv) rr = rr - 1;
        while ((rr + 1) * (rr + 1) <= vv) rr = rr + 1;
        return rr[63:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [2*W-1:0] v, output logic [W-1:0] r_o,
                          output logic [W:0] m_o, output int lat, output logic ex_o);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        check("in_ready_before_accept", {127'd0, in_ready}, 128'd1);
        x        = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        r_o  = root;
        m_o  = rem;
        ex_o = 1'b0;
`ifdef ISQRT_EXACT_FLAG_EN
        ex_o = exact;
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("in_ready_after_handoff", {127'd0, in_ready}, 128'd1);
        check("out_valid_after_handoff", {127'd0, out_valid}, 128'd0);
    endtask

    vec_t           vecs [10];
    logic [W-1:0]   r_got;
    logic [W:0]     m_got;
    int             lat;
    logic           ex_got;
    logic [2*W-1:0] q_x [$];
    logic [2*W-1:0] exp_x;
    logic [63:0]    mr;
    logic [127:0]   sq;
    int             sent;
    int             recv;
    int             cyc;
    logic           accept_now;
    logic           take_now;

    initial begin
        vecs[0] = '{x: 64'd144,                  root: 32'd12,         rem: 33'd0};
        vecs[1] = '{x: 64'd145,                  root: 32'd12,         rem: 33'd1};
        vecs[2] = '{x: 64'd0,                    root: 32'd0,          rem: 33'd0};
        vecs[3] = '{x: 64'hFFFFFFFF_FFFFFFFF,    root: 32'hFFFFFFFF,   rem: 33'h1_FFFFFFFE};
        vecs[4] = '{x: 64'd1000,                 root: 32'd31,         rem: 33'd39};
        vecs[5] = '{x: 64'h100_0000_0000,        root: 32'h10_0000,    rem: 33'd0};
        vecs[6] = '{x: 64'd1,                    root: 32'd1,          rem: 33'd0};
        vecs[7] = '{x: 64'd3,                    root: 32'd1,          rem: 33'd2};
        vecs[8] = '{x: 64'd4,                    root: 32'd2,          rem: 33'd0};
        vecs[9] = '{x: 64'hFFFFFFFE_00000001,    root: 32'hFFFFFFFF,   rem: 33'd0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0;
        tick(); tick();
        check("reset_in_ready", {127'd0, in_ready}, 128'd1);
        check("reset_out_valid", {127'd0, out_valid}, 128'd0);
        check("reset_root", {96'd0, root}, 128'd0);
        check("reset_rem", {95'd0, rem}, 128'd0);
`ifdef ISQRT_EXACT_FLAG_EN
        check("reset_exact", {127'd0, exact}, 128'd0);
`endif
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].x, r_got, m_got, lat, ex_got);
            check($sformatf("vec%0d_latency", i), 128'(lat), 128'd32);
            check($sformatf("vec%0d_root", i), {96'd0, r_got}, {96'd0, vecs[i].root});
            check($sformatf("vec%0d_rem", i), {95'd0, m_got}, {95'd0, vecs[i].rem});
`ifdef ISQRT_EXACT_FLAG_EN
            check($sformatf("vec%0d_exact", i), {127'd0, ex_got}, {127'd0, vecs[i].rem == 0});
`endif
        end

        // Backpressure: hold the result for 10 cycles while in_valid and x wander.
        x = 64'd1000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 32; i++) tick();
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", {127'd0, out_valid}, 128'd1);
            check("bp_in_ready", {127'd0, in_ready}, 128'd0);
            check("bp_root", {96'd0, root}, 128'd31);
            check("bp_rem", {95'd0, rem}, 128'd39);
            in_valid = ~in_valid;
            x = {$urandom, $urandom};
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_in_ready", {127'd0, in_ready}, 128'd1);
        check("bp_release_out_valid", {127'd0, out_valid}, 128'd0);

        // Reset during iteration 16 discards the operation.
        x = 64'h100_0000_0000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        rst = 1'b1;
        tick();
        check("rst_mid_in_ready", {127'd0, in_ready}, 128'd1);
        check("rst_mid_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_mid_root", {96'd0, root}, 128'd0);
        check("rst_mid_rem", {95'd0, rem}, 128'd0);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) break;
            tick();
        end
        check("rst_mid_no_pulse", {127'd0, out_valid}, 128'd0);
        run_op(64'h100_0000_0000, r_got, m_got, lat, ex_got);
        check("rst_redo_root", {96'd0, r_got}, 128'h10_0000);
        check("rst_redo_rem", {95'd0, m_got}, 128'd0);

        // Radicand changes after acceptance must not disturb the result.
        x = 64'd145; in_valid = 1'b1;
        tick();
        x = 64'd9;
        for (int i = 0; i < 32; i++) tick();
        check("xchg_out_valid", {127'd0, out_valid}, 128'd1);
        for (int i = 0; i < 3; i++) begin
            x = {$urandom, $urandom};
            tick();
            check("xchg_root", {96'd0, root}, 128'd12);
            check("xchg_rem", {95'd0, rem}, 128'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Randomized back-to-back stream, in_valid held, random consumer.
        sent = 0; recv = 0; cyc = 0;
        in_valid = 1'b1;
        x = {$urandom, $urandom};
        while (recv < 1000 && cyc < 90000) begin
            out_ready  = ($urandom_range(0, 1) == 1);
            accept_now = in_ready && in_valid;
            take_now   = out_valid && out_ready;
            if (take_now) begin
                if (q_x.size() == 0) begin
                    check("stream_unexpected_result", 128'd1, 128'd0);
                end else begin
                    exp_x = q_x.pop_front();
                    mr = model_root(exp_x);
                    check("stream_root", {96'd0, root}, {64'd0, mr});
                    check("stream_rem", {95'd0, rem}, {64'd0, exp_x} - {64'd0, mr} * {64'd0, mr});
                    sq = {96'd0, root} * {96'd0, root} + {95'd0, rem};
                    check("stream_identity", sq, {64'd0, exp_x});
                    check("stream_rem_bound", {127'd0, {95'd0, rem} <= 2 * {96'd0, root}}, 128'd1);
                end
                recv++;
            end
            if (accept_now) q_x.push_back(x);
            tick();
            cyc++;
            if (accept_now) begin
                sent++;
                case ($urandom_range(0, 3))
                    0:       x = {32'd0, $urandom};
                    1:       x = {$urandom, $urandom} >> $urandom_range(0, 63);
                    default: x = {$urandom, $urandom};
                endcase
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("stream_all_received", 128'(recv), 128'd1000);
        check("stream_queue_drained", 128'(q_x.size() <= 1), 128'd1);

        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule
